// File: rtl/memshare_ibram_remap_ctrl_pkg.sv
// Shared defaults and FSM encoding for the IB-LUT rank remap controller.
package memshare_ibram_remap_ctrl_pkg;

  localparam int SHARE_GROUP_SIZE_DEF   = 4;
  localparam int QUAN_SIZE_DEF          = 4;
  localparam int GP1_RAM_ADDR_WIDTH_DEF = 5;
  localparam int GP2_RAM_ADDR_WIDTH_DEF = 6;
  localparam int ITER_ID_WIDTH_DEF      = 5;
  localparam logic [3:0] SHARE_COL_CONFIG_DEF = 4'b1010;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    LOAD  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } remap_state_e;

  localparam logic [2:0] ST_IDLE  = IDLE;
  localparam logic [2:0] ST_PREP  = PREP;
  localparam logic [2:0] ST_LOAD  = LOAD;
  localparam logic [2:0] ST_DRAIN = DRAIN;
  localparam logic [2:0] ST_DONE  = DONE;

endpackage

// File: rtl/memshare_ibram_remap_ctrl_we_gen.sv
// Per-VN write-enable mask: GP2 VNs accept every address, GP1 VNs only the lower GP1 range.
module memshare_ibram_remap_ctrl_we_gen
  import memshare_ibram_remap_ctrl_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE   = SHARE_GROUP_SIZE_DEF,
  parameter int GP1_RAM_ADDR_WIDTH = GP1_RAM_ADDR_WIDTH_DEF,
  parameter int GP2_RAM_ADDR_WIDTH = GP2_RAM_ADDR_WIDTH_DEF,
  parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG = SHARE_GROUP_SIZE'(SHARE_COL_CONFIG_DEF)
) (
  input  logic [GP2_RAM_ADDR_WIDTH-1:0] addr_i,
  output logic [SHARE_GROUP_SIZE-1:0]   we_mask_o
);

  localparam logic [GP2_RAM_ADDR_WIDTH-1:0] GP1_DEPTH =
    GP2_RAM_ADDR_WIDTH'(1 << GP1_RAM_ADDR_WIDTH);

  logic in_gp1_range;

  assign in_gp1_range = (addr_i < GP1_DEPTH);
  assign we_mask_o    = SHARE_COL_CONFIG | {SHARE_GROUP_SIZE{in_gp1_range}};

endmodule

// File: rtl/memshare_ibram_remap_ctrl.sv
// Reload sequencer for one share-group rank of IB-LUTs: streams 2^GP2 entries into the rank while stalling reads.
module memshare_ibram_remap_ctrl
  import memshare_ibram_remap_ctrl_pkg::*;
#(
  parameter int SHARE_GROUP_SIZE   = SHARE_GROUP_SIZE_DEF,
  parameter int QUAN_SIZE          = QUAN_SIZE_DEF,
  parameter int GP1_RAM_ADDR_WIDTH = GP1_RAM_ADDR_WIDTH_DEF,
  parameter int GP2_RAM_ADDR_WIDTH = GP2_RAM_ADDR_WIDTH_DEF,
  parameter logic [SHARE_GROUP_SIZE-1:0] SHARE_COL_CONFIG = SHARE_GROUP_SIZE'(SHARE_COL_CONFIG_DEF),
  parameter int ITER_ID_WIDTH      = ITER_ID_WIDTH_DEF
) (
  input  logic                          sys_clk,
  input  logic                          rstn,
  input  logic                          start_i,
  input  logic [ITER_ID_WIDTH-1:0]      iter_id_i,
  input  logic                          ent_valid_i,
  input  logic [QUAN_SIZE-1:0]          ent_data_i,
  output logic                          ent_ready_o,
  output logic                          remap_en_n,
  output logic [GP2_RAM_ADDR_WIDTH-1:0] remap_addr_o,
  output logic [QUAN_SIZE-1:0]          remap_data_o,
  output logic [SHARE_GROUP_SIZE-1:0]   vn_we_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [ITER_ID_WIDTH-1:0]      iter_id_o,
  output logic                          start_err_o
);

  localparam int CNT_W = GP2_RAM_ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << GP2_RAM_ADDR_WIDTH) - 1);

  logic [2:0]                    state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic [GP2_RAM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [QUAN_SIZE-1:0]          data_q, data_d;
  logic [SHARE_GROUP_SIZE-1:0]   we_q, we_d;
  logic [ITER_ID_WIDTH-1:0]      iter_q, iter_d;
  logic                          err_q, err_d;
  logic                          beat;
  logic [SHARE_GROUP_SIZE-1:0]   we_mask;

  memshare_ibram_remap_ctrl_we_gen #(
    .SHARE_GROUP_SIZE   (SHARE_GROUP_SIZE),
    .GP1_RAM_ADDR_WIDTH (GP1_RAM_ADDR_WIDTH),
    .GP2_RAM_ADDR_WIDTH (GP2_RAM_ADDR_WIDTH),
    .SHARE_COL_CONFIG   (SHARE_COL_CONFIG)
  ) u_we_gen (
    .addr_i    (cnt_q[GP2_RAM_ADDR_WIDTH-1:0]),
    .we_mask_o (we_mask)
  );

  assign ent_ready_o = (state_q == ST_LOAD);
  assign beat        = ent_valid_i & ent_ready_o;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    iter_d  = iter_q;
    we_d    = '0;
    // Any start outside IDLE (including the DONE cycle) is a protocol error.
    err_d   = start_i & (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          iter_d  = iter_id_i;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        cnt_d   = '0;
        state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (beat) begin
          addr_d = cnt_q[GP2_RAM_ADDR_WIDTH-1:0];
          data_d = ent_data_i;
          we_d   = we_mask;
          // Terminal beat: leave LOAD without bumping the counter, so ready drops on this edge.
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= '0;
      iter_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      iter_q  <= iter_d;
      err_q   <= err_d;
    end
  end

  assign remap_en_n   = ~((state_q == ST_PREP) | (state_q == ST_LOAD) | (state_q == ST_DRAIN));
  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_DONE);
  assign remap_addr_o = addr_q;
  assign remap_data_o = data_q;
  assign vn_we_o      = we_q;
  assign iter_id_o    = iter_q;
  assign start_err_o  = err_q;

endmodule
